// File: rtl/hazard_forward_unit_pkg.sv
// Shared encodings for the hazard/forwarding block and the EX operand muxes.
// Combinational definitions only; no backpressure.
package hazard_forward_unit_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b10;
  localparam fwd_sel_t FWD_MEMWB = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MULTI_BUSY = 2'd2
  } hfu_state_e;

  // The younger EX/MEM result always wins over MEM/WB.
  function automatic fwd_sel_t fwd_pick(input logic exmem_hit, input logic memwb_hit);
    if (exmem_hit)      return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else                return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side view of the hazard/forwarding unit: stage info in, stall controls out.
// Wires only; no latency, no backpressure.
interface hazard_forward_unit_if #(
  parameter int AW    = 4,
  parameter int NSRC  = 2,
  parameter int CNT_W = 16
);
  logic                 flush;
  logic [NSRC*AW-1:0]   id_src_addr;
  logic [NSRC-1:0]      id_src_valid;
  logic [NSRC*AW-1:0]   ex_src_addr;
  logic                 ex_valid;
  logic [AW-1:0]        ex_dst_addr;
  logic                 ex_reg_write;
  logic                 ex_is_load;
  logic                 ex_is_multi;
  logic [AW-1:0]        exmem_dst_addr;
  logic                 exmem_reg_write;
  logic [AW-1:0]        memwb_dst_addr;
  logic                 memwb_reg_write;
  logic [2*NSRC-1:0]    forward_sel;
  logic                 stall_front;
  logic                 bubble_idex;
  logic                 hold_ex;
  logic                 busy;
  logic [CNT_W-1:0]     stall_count;

  modport master (
    output flush, id_src_addr, id_src_valid, ex_src_addr, ex_valid, ex_dst_addr,
           ex_reg_write, ex_is_load, ex_is_multi, exmem_dst_addr, exmem_reg_write,
           memwb_dst_addr, memwb_reg_write,
    input  forward_sel, stall_front, bubble_idex, hold_ex, busy, stall_count
  );

  modport slave (
    input  flush, id_src_addr, id_src_valid, ex_src_addr, ex_valid, ex_dst_addr,
           ex_reg_write, ex_is_load, ex_is_multi, exmem_dst_addr, exmem_reg_write,
           memwb_dst_addr, memwb_reg_write,
    output forward_sel, stall_front, bubble_idex, hold_ex, busy, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit_fwd_select.sv
// Forward-source select for one EX operand; register 0 is never forwarded.
// Purely combinational, zero latency, no backpressure.
module hazard_forward_unit_fwd_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] exmem_dst_addr,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] memwb_dst_addr,
  input  logic          memwb_reg_write,
  output fwd_sel_t      sel
);

  logic exmem_hit;
  logic memwb_hit;

  always_comb begin
    exmem_hit = exmem_reg_write && (exmem_dst_addr != '0) && (exmem_dst_addr == src_addr);
    memwb_hit = memwb_reg_write && (memwb_dst_addr != '0) && (memwb_dst_addr == src_addr);
    sel       = fwd_pick(exmem_hit, memwb_hit);
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding, load-use stall and multi-cycle EX sequencing with a stall counter.
// Forwarding and first-cycle stall are combinational; follow-on stalls come from the FSM; flush aborts.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int AW        = 4,
  parameter int NSRC      = 2,
  parameter int LOAD_LAT  = 1,
  parameter int MULTI_LAT = 4,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  hazard_forward_unit_if.slave bus
);

  localparam int LCW = $clog2(LOAD_LAT + 1);
  localparam int MCW = $clog2(MULTI_LAT + 1);
  localparam logic [LCW-1:0] LOAD_INIT  = LCW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [MCW-1:0] MULTI_INIT = MCW'(MULTI_LAT - 2);

  hfu_state_e         state;
  logic [LCW-1:0]     load_cnt;
  logic [MCW-1:0]     multi_cnt;
  logic [CNT_W-1:0]   stall_cnt;
  logic [2*NSRC-1:0]  fwd_sel;
  logic               src_hit;
  logic               lu;
  logic               multi_start;
  logic               stall_front;

  for (genvar k = 0; k < NSRC; k++) begin : g_fwd
    hazard_forward_unit_fwd_select #(.AW(AW)) u_fwd_select (
      .src_addr        (bus.ex_src_addr[k*AW +: AW]),
      .exmem_dst_addr  (bus.exmem_dst_addr),
      .exmem_reg_write (bus.exmem_reg_write),
      .memwb_dst_addr  (bus.memwb_dst_addr),
      .memwb_reg_write (bus.memwb_reg_write),
      .sel             (fwd_sel[2*k +: 2])
    );
  end

  always_comb begin
    src_hit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (bus.id_src_valid[k] && (bus.id_src_addr[k*AW +: AW] == bus.ex_dst_addr)) begin
        src_hit = 1'b1;
      end
    end
    lu = (state == ST_RUN) && bus.ex_valid && bus.ex_is_load && bus.ex_reg_write &&
         (bus.ex_dst_addr != '0) && src_hit;
    multi_start = (state == ST_RUN) && !lu && bus.ex_valid && bus.ex_is_multi;
    stall_front = !bus.flush && (lu || multi_start || (state != ST_RUN));
  end

  assign bus.forward_sel = fwd_sel;
  assign bus.stall_front = stall_front;
  assign bus.bubble_idex = !bus.flush && (lu || (state == ST_LOAD_STALL));
  assign bus.hold_ex     = !bus.flush && (multi_start || (state == ST_MULTI_BUSY));
  assign bus.busy        = (state != ST_RUN);
  assign bus.stall_count = stall_cnt;

  // The first stall cycle is spent in RUN, so the FSM only covers the remaining ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      load_cnt  <= '0;
      multi_cnt <= '0;
    end else if (bus.flush) begin
      state     <= ST_RUN;
      load_cnt  <= '0;
      multi_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (lu) begin
            if (LOAD_LAT > 1) begin
              state    <= ST_LOAD_STALL;
              load_cnt <= LOAD_INIT;
            end
          end else if (multi_start && (MULTI_LAT > 2)) begin
            state     <= ST_MULTI_BUSY;
            multi_cnt <= MULTI_INIT;
          end
        end
        ST_LOAD_STALL: begin
          if (load_cnt == '0) state <= ST_RUN;
          else                load_cnt <= load_cnt - 1'b1;
        end
        ST_MULTI_BUSY: begin
          multi_cnt <= multi_cnt - 1'b1;
          if (multi_cnt == MCW'(1)) state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              stall_cnt <= '0;
    else if (stall_front && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed then random stimulus against a remaining-stall-cycles model of the hazard unit.
module tb_hazard_forward_unit;
  localparam int AW = 4, NSRC = 2, LOAD_LAT = 2, MULTI_LAT = 4, CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.AW(AW), .NSRC(NSRC), .CNT_W(CNT_W)) bus ();

  hazard_forward_unit #(.AW(AW), .NSRC(NSRC), .LOAD_LAT(LOAD_LAT),
                        .MULTI_LAT(MULTI_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // model: stall cycles still owed after the current one, and what kind of stall
  int rem = 0;
  int kind = 0;
  int m_count = 0;
  logic [2*NSRC-1:0] e_fsel;
  logic e_sf, e_bub, e_hold, e_busy, e_lu, e_multi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input int src);
    if (bus.exmem_reg_write && bus.exmem_dst_addr != 0 && int'(bus.exmem_dst_addr) == src) return 2'b10;
    if (bus.memwb_reg_write && bus.memwb_dst_addr != 0 && int'(bus.memwb_dst_addr) == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit hit = 0;
    for (int k = 0; k < NSRC; k++) begin
      e_fsel[2*k +: 2] = ref_fwd(int'(bus.ex_src_addr[k*AW +: AW]));
      if (bus.id_src_valid[k] && bus.id_src_addr[k*AW +: AW] == bus.ex_dst_addr) hit = 1;
    end
    e_busy  = (rem > 0);
    e_lu    = (rem == 0) && bus.ex_valid && bus.ex_is_load && bus.ex_reg_write &&
              (bus.ex_dst_addr != 0) && hit;
    e_multi = (rem == 0) && !e_lu && bus.ex_valid && bus.ex_is_multi;
    e_sf    = !bus.flush && (rem > 0 || e_lu || e_multi);
    e_bub   = !bus.flush && ((rem > 0 && kind == 1) || e_lu);
    e_hold  = !bus.flush && ((rem > 0 && kind == 2) || e_multi);
  endtask

  task automatic model_step();
    if (rst) begin
      rem = 0; kind = 0; m_count = 0;
    end else begin
      if (e_sf && m_count < CNT_MAX) m_count++;
      if (bus.flush)    begin rem = 0; kind = 0; end
      else if (rem > 0) rem--;
      else if (e_lu)    begin rem = LOAD_LAT - 1;  kind = 1; end
      else if (e_multi) begin rem = MULTI_LAT - 2; kind = 2; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    if (!rst) begin
      chk("forward_sel", 32'(bus.forward_sel), 32'(e_fsel));
      chk("stall_front", 32'(bus.stall_front), 32'(e_sf));
      chk("bubble_idex", 32'(bus.bubble_idex), 32'(e_bub));
      chk("hold_ex",     32'(bus.hold_ex),     32'(e_hold));
      chk("busy",        32'(bus.busy),        32'(e_busy));
      chk("stall_count", 32'(bus.stall_count), 32'(m_count));
    end
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 0; bus.id_src_addr = '0; bus.id_src_valid = '0; bus.ex_src_addr = '0;
    bus.ex_valid = 0; bus.ex_dst_addr = '0; bus.ex_reg_write = 0; bus.ex_is_load = 0;
    bus.ex_is_multi = 0; bus.exmem_dst_addr = '0; bus.exmem_reg_write = 0;
    bus.memwb_dst_addr = '0; bus.memwb_reg_write = 0;
  endtask

  task automatic set_load(input int dst, input int id0, input logic vld);
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_reg_write = 1; bus.ex_dst_addr = AW'(dst);
    bus.id_src_addr[AW-1:0] = AW'(id0); bus.id_src_valid = {1'b0, vld};
  endtask

  initial begin
    idle();
    rst = 1; tick(); tick();
    rst = 0; tick();
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_count", 32'(bus.stall_count), 32'd0);

    // forwarding priority and register 0
    bus.exmem_dst_addr = 3; bus.exmem_reg_write = 1;
    bus.memwb_dst_addr = 3; bus.memwb_reg_write = 1;
    bus.ex_src_addr = {AW'(0), AW'(3)};
    tick(); chk("fwd_exmem_prio", 32'(bus.forward_sel[1:0]), 32'b10);
    bus.exmem_reg_write = 0;
    tick(); chk("fwd_memwb", 32'(bus.forward_sel[1:0]), 32'b01);
    bus.exmem_reg_write = 1; bus.exmem_dst_addr = 0; bus.memwb_dst_addr = 0; bus.ex_src_addr = '0;
    tick(); chk("fwd_r0", 32'(bus.forward_sel[1:0]), 32'b00);
    bus.exmem_dst_addr = 2; bus.memwb_dst_addr = 5; bus.ex_src_addr = {AW'(5), AW'(2)};
    tick(); chk("fwd_two_slots", 32'(bus.forward_sel), 32'b0110);
    idle();

    // load-use: two stall cycles then RUN
    set_load(4, 4, 1'b1);
    tick(); chk("lu_busy_after_first", 32'(bus.busy), 32'd1);
    idle(); tick(); tick();
    chk("lu_count", 32'(bus.stall_count), 32'd2);
    chk("lu_back_to_run", 32'(bus.busy), 32'd0);
    set_load(4, 4, 1'b0);
    tick(); chk("lu_unused_src", 32'(bus.stall_front), 32'd0);
    idle();

    // multi-cycle pulse: three stall cycles
    bus.ex_valid = 1; bus.ex_is_multi = 1;
    tick(); idle(); tick(); tick(); tick();
    chk("multi_done", 32'(bus.busy), 32'd0);

    // flush in the second MULTI_BUSY cycle
    bus.ex_valid = 1; bus.ex_is_multi = 1;
    tick(); idle(); tick();
    bus.flush = 1; tick();
    bus.flush = 0; chk("flush_run", 32'(bus.busy), 32'd0);
    tick();

    // reset in the middle of a load stall
    set_load(7, 7, 1'b1);
    tick(); idle();
    rst = 1; tick(); rst = 0;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_count", 32'(bus.stall_count), 32'd0);
    tick();

    // continuous load-use keeps stall_front high; counter must saturate
    set_load(6, 6, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("count_saturate", 32'(bus.stall_count), 32'(CNT_MAX));
    idle();
    rst = 1; tick(); rst = 0; tick();

    for (int i = 0; i < 400; i++) begin
      bus.flush           = ($urandom_range(0, 19) == 0);
      bus.id_src_addr     = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      bus.id_src_valid    = NSRC'($urandom_range(0, 3));
      bus.ex_src_addr     = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      bus.ex_valid        = ($urandom_range(0, 3) != 0);
      bus.ex_dst_addr     = AW'($urandom_range(0, 3));
      bus.ex_reg_write    = $urandom_range(0, 1) == 1;
      bus.ex_is_load      = ($urandom_range(0, 2) == 0);
      bus.ex_is_multi     = ($urandom_range(0, 5) == 0);
      bus.exmem_dst_addr  = AW'($urandom_range(0, 3));
      bus.exmem_reg_write = $urandom_range(0, 1) == 1;
      bus.memwb_dst_addr  = AW'($urandom_range(0, 3));
      bus.memwb_reg_write = $urandom_range(0, 1) == 1;
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the single-operand forwarding logic. It forwards to NSRC EX-stage source operands from the EX/MEM and MEM/WB stages.
- It detects load-use hazards and stalls for a configurable load latency.
- It sequences multi-cycle EX operations (mul/div) with a busy counter.
- It sits beside the ID/EX, EX/MEM and MEM/WB buffers. It drives the PC/IF-ID hold, ID/EX bubble and EX hold controls, and exposes a saturating stall-cycle counter.

Parameters:
- AW, 4, register address width
- NSRC, 2, source operands per instruction
- LOAD_LAT, 1, stall cycles inserted per load-use hazard (>=1)
- MULTI_LAT, 4, total EX cycles of a multi-cycle op (>=2)
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  branch/exception flush, aborts any stall
- id_src_addr  in  NSRC*AW  source register addresses of instruction in ID; slot k = bits [k*AW +: AW]
- id_src_valid  in  NSRC  per-slot "source used"
- ex_src_addr  in  NSRC*AW  source addresses of instruction in EX (from ID/EX buffer)
- ex_valid  in  1  EX holds a real instruction
- ex_dst_addr  in  AW  EX destination
- ex_reg_write  in  1  EX writes a register
- ex_is_load  in  1  EX instruction is a load
- ex_is_multi  in  1  EX instruction is multi-cycle
- exmem_dst_addr  in  AW  EX/MEM destination
- exmem_reg_write  in  1  EX/MEM writes a register
- memwb_dst_addr  in  AW  MEM/WB destination
- memwb_reg_write  in  1  MEM/WB writes a register
- forward_sel  out  2*NSRC  per-slot mux select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- stall_front  out  1  hold PC and IF/ID buffer
- bubble_idex  out  1  load NOP into ID/EX buffer
- hold_ex  out  1  hold ID/EX contents, bubble into EX/MEM
- busy  out  1  FSM not in RUN
- stall_count  out  CNT_W  cycles with stall_front=1, saturating

Behaviour:
- Reset (sync, rst=1 at posedge): state RUN, load_cnt=0, multi_cnt=0, stall_count=0. All control outputs read 0 in the cycle after reset. forward_sel stays combinational throughout.
- Forwarding, combinational per slot k:
  - 10 if exmem_reg_write & exmem_dst!=0 & exmem_dst==ex_src[k];
  - else 01 if memwb_reg_write & memwb_dst!=0 & memwb_dst==ex_src[k];
  - else 00.
  - EX/MEM always has priority. Register 0 is never forwarded.
- Load-use detect (combinational, "lu"): state==RUN & ex_valid & ex_is_load & ex_reg_write & ex_dst!=0 & any k with id_src_valid[k] & id_src[k]==ex_dst.
- FSM states RUN, LOAD_STALL, MULTI_BUSY.
  - RUN:
    - If lu: stall_front=1 and bubble_idex=1 this cycle. If LOAD_LAT>1, go to LOAD_STALL with load_cnt=LOAD_LAT-2.
    - Else if ex_valid & ex_is_multi: stall_front=1 and hold_ex=1 this cycle, go to MULTI_BUSY with multi_cnt=MULTI_LAT-2.
    - lu has priority over multi.
  - LOAD_STALL: stall_front=1, bubble_idex=1. Decrement load_cnt; when load_cnt==0, return to RUN next cycle.
  - MULTI_BUSY: stall_front=1, hold_ex=1. Decrement multi_cnt; when multi_cnt==0, return to RUN. The op's final EX cycle is the RUN cycle after exit.
- busy = (state!=RUN).
- flush=1: next state RUN, counters 0. Stall/hold/bubble outputs are forced 0 in the flush cycle. Flush has priority over detection. rst has priority over flush.
- stall_count increments each cycle stall_front=1. It holds at all-ones.
- Total stall cycles: load-use = LOAD_LAT; multi op = MULTI_LAT-1.

Decomposition:
- Shared package: forward-select encodings (FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01) and FSM state enum, reused by the datapath operand muxes.
- One sub-module, fwd_select: per-slot combinational priority compare, instantiated NSRC times via generate.

Test Plan:
- EX/MEM dst=3 write, MEM/WB dst=3 write, ex_src0=3 -> forward_sel[1:0]=10. Drop exmem_reg_write -> 01. Set dst=0 -> 00.
- ex_src1=5 matches memwb only, ex_src0=2 matches exmem -> forward_sel=01_10.
- LOAD_LAT=2: load dst=4 in EX, id_src0=4 valid -> stall_front and bubble_idex high exactly 2 cycles, then RUN. stall_count=2. id_src_valid=0 -> no stall.
- MULTI_LAT=4: ex_is_multi pulse -> stall_front and hold_ex high 3 cycles. busy high cycles 2-3. Returns to RUN.
- flush asserted in the 2nd MULTI_BUSY cycle -> outputs 0 that cycle, RUN next, counters 0. rst mid-LOAD_STALL -> all 0 after the next edge.
- Drive CNT_W=4 with a continuous stall -> stall_count saturates at 15.
